// File: rtl/adder_arb6.sv
// Round-robin arbiter that shares one three-stage, six-operand adder among N requesters.
// Each requester owns a result slot (IDLE -> INFLIGHT -> DONE -> IDLE), and results are returned to it by ID.
module adder_arb6 #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N*6*W-1:0] req_ops,
  output logic [N-1:0]     req_ready,
  output logic [N-1:0]     rsp_valid,
  output logic [N*W-1:0]   rsp_data,
  input  logic [N-1:0]     rsp_ready,
  output logic             busy,
  output logic [2*N-1:0]   o_dbg_slot_st
);
  // Handshakes: a job transfers on req_valid[i] & req_ready[i], and a result transfers on
  // rsp_valid[i] & rsp_ready[i]. Both are sampled on the rising clock edge. req_ready never looks at rsp_ready.

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    SLOT_IDLE     = 2'd0,
    SLOT_INFLIGHT = 2'd1,
    SLOT_DONE     = 2'd2
  } slot_st_e;

  slot_st_e      r_slot_st  [N];
  slot_st_e      w_slot_nxt [N];
  logic [PW-1:0] r_ptr;
  logic [N-1:0]  w_elig;
  logic          w_grant_vld;
  logic [PW-1:0] w_grant_id;
  logic [W-1:0]  w_ops [6];

  logic          r_s1_vld;
  logic [PW-1:0] r_s1_id;
  logic [W-1:0]  r_p0, r_p1, r_p2;
  logic          r_s2_vld;
  logic [PW-1:0] r_s2_id;
  logic [W-1:0]  r_s01, r_p2d;
  logic [W-1:0]  r_rsp_data [N];

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % N;
    return s[PW-1:0];
  endfunction

  // rst_n gates eligibility, so req_ready stays low while reset is held.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N; i++) begin
      w_elig[i] = req_valid[i] & (r_slot_st[i] == SLOT_IDLE) & rst_n;
    end
  end

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_grant_vld && w_elig[rr_idx(r_ptr, k)]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = rr_idx(r_ptr, k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_grant_vld) begin
      req_ready[w_grant_id] = 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < 6; k++) begin
      w_ops[k] = req_ops[(6 * int'(w_grant_id) + k) * W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_grant_vld) begin
      r_ptr <= (w_grant_id == PW'(N - 1)) ? '0 : w_grant_id + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_id  <= '0;
      r_p0     <= '0;
      r_p1     <= '0;
      r_p2     <= '0;
      r_s2_vld <= 1'b0;
      r_s2_id  <= '0;
      r_s01    <= '0;
      r_p2d    <= '0;
      for (int i = 0; i < N; i++) begin
        r_rsp_data[i] <= '0;
      end
    end else begin
      r_s1_vld <= w_grant_vld;
      r_s1_id  <= w_grant_id;
      r_p0     <= w_ops[0] + w_ops[1];
      r_p1     <= w_ops[2] + w_ops[3];
      r_p2     <= w_ops[4] + w_ops[5];
      r_s2_vld <= r_s1_vld;
      r_s2_id  <= r_s1_id;
      r_s01    <= r_p0 + r_p1;
      r_p2d    <= r_p2;
      if (r_s2_vld) begin
        r_rsp_data[r_s2_id] <= r_s01 + r_p2d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_slot_st[i] <= SLOT_IDLE;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        r_slot_st[i] <= w_slot_nxt[i];
      end
    end
  end

  // Each slot sits in exactly one state, so a grant, a writeback and a handshake never compete for the same slot.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_slot_nxt[i] = r_slot_st[i];
      case (r_slot_st[i])
        SLOT_IDLE:     if (w_grant_vld && (w_grant_id == PW'(i))) w_slot_nxt[i] = SLOT_INFLIGHT;
        SLOT_INFLIGHT: if (r_s2_vld && (r_s2_id == PW'(i)))       w_slot_nxt[i] = SLOT_DONE;
        SLOT_DONE:     if (rsp_ready[i])                          w_slot_nxt[i] = SLOT_IDLE;
        default:       w_slot_nxt[i] = SLOT_IDLE;
      endcase
    end
  end

  always_comb begin
    rsp_valid     = '0;
    rsp_data      = '0;
    o_dbg_slot_st = '0;
    busy          = 1'b0;
    for (int i = 0; i < N; i++) begin
      rsp_valid[i]            = (r_slot_st[i] == SLOT_DONE);
      rsp_data[i*W +: W]      = r_rsp_data[i];
      o_dbg_slot_st[2*i +: 2] = r_slot_st[i];
      busy                    = busy | (r_slot_st[i] != SLOT_IDLE);
    end
  end

endmodule

// File: tb/tb_adder_arb6.sv
// Bench for adder_arb6. A latency/slot model (fixed three-cycle result, round-robin pick)
// predicts the outputs, and a scoreboard pairs every rising rsp_valid with the job it belongs to.
module tb_adder_arb6;
  localparam int W = 16;
  localparam int N = 4;
  localparam int ST_IDLE = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_DONE = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*6*W-1:0] req_ops = '0;
  logic [N-1:0]     rsp_ready = '0;
  wire  [N-1:0]     req_ready;
  wire  [N-1:0]     rsp_valid;
  wire  [N*W-1:0]   rsp_data;
  wire              busy;
  wire  [2*N-1:0]   dbg_slot_st;

  adder_arb6 #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ops(req_ops),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy), .o_dbg_slot_st(dbg_slot_st)
  );

  always #5 clk = ~clk;

  int           m_st   [N];
  logic [W-1:0] m_data [N];
  logic [W-1:0] m_sum  [N];
  int           m_due  [N];
  int           m_ptr;
  int           cyc;
  logic [W-1:0] exp_q[$];
  int           exp_id_q[$];
  int           n_checks = 0;
  int           n_fail = 0;

  function automatic logic [W-1:0] op_of(input int i, input int k);
    return req_ops[(6*i+k)*W +: W];
  endfunction

  function automatic logic [W-1:0] job_sum(input int i);
    longint t;
    t = 0;
    for (int k = 0; k < 6; k++) t += longint'(op_of(i, k));
    return t[W-1:0];
  endfunction

  function automatic int m_grant();
    int idx;
    if (!rst_n) return -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (req_valid[idx] && m_st[idx] == ST_IDLE) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = m_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [N-1:0] exp_rsp_valid();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (m_st[i] == ST_DONE);
    return r;
  endfunction

  function automatic logic exp_busy();
    logic b;
    b = 1'b0;
    for (int i = 0; i < N; i++) if (m_st[i] != ST_IDLE) b = 1'b1;
    return b;
  endfunction

  function automatic logic [N*W-1:0] exp_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = m_data[i];
    return d;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = ST_IDLE; m_data[i] = '0; m_sum[i] = '0; m_due[i] = 0;
    end
    m_ptr = 0;
    cyc = 0;
    exp_q.delete();
    exp_id_q.delete();
  endtask

  task automatic set_op(input int i, input int k, input logic [W-1:0] v);
    req_ops[(6*i+k)*W +: W] = v;
  endtask

  task automatic rand_ops(input int i);
    for (int k = 0; k < 6; k++) set_op(i, k, W'($urandom()));
  endtask

  // One clock: model decisions use the inputs as the DUT samples them; returns on the falling edge.
  task automatic tick();
    int g;
    logic [N-1:0] hs;
    logic [W-1:0] s;
    g = m_grant();
    s = (g >= 0) ? job_sum(g) : '0;
    for (int i = 0; i < N; i++) hs[i] = rst_n && (m_st[i] == ST_DONE) && rsp_ready[i];
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else begin
      for (int i = 0; i < N; i++) if (hs[i]) m_st[i] = ST_IDLE;
      if (g >= 0) begin
        m_st[g] = ST_BUSY; m_due[g] = cyc + 3; m_sum[g] = s; m_ptr = (g + 1) % N;
        exp_q.push_back(s);
        exp_id_q.push_back(g);
      end
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (m_st[i] == ST_BUSY && m_due[i] == cyc) begin
          m_st[i] = ST_DONE; m_data[i] = m_sum[i];
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    req_valid = '0; rsp_ready = '1;
    n = 0;
    while (exp_busy() && n < 20) begin tick(); n++; end
    if (exp_busy()) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: slots still busy after %0d cycles, required idle", n);
    end
  endtask

  // Scoreboard: each new result must match, in order, the next accepted job.
  initial begin
    logic [N-1:0] sb_prev;
    logic [W-1:0] e;
    int id;
    sb_prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_prev = '0; exp_q.delete(); exp_id_q.delete();
      end else begin
        for (int i = 0; i < N; i++) begin
          if (rsp_valid[i] && !sb_prev[i]) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL sb_unexpected: slot %0d result %h, required no response", i, rsp_data[i*W +: W]);
            end else begin
              e = exp_q.pop_front();
              id = exp_id_q.pop_front();
              if (id !== i || rsp_data[i*W +: W] !== e) begin
                n_fail++;
                $display("FAIL sb_result: slot %0d data %h, required slot %0d data %h", i, rsp_data[i*W +: W], id, e);
              end
            end
          end
        end
        sb_prev = rsp_valid;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_valid = N'($urandom()); rsp_ready = N'($urandom());
      for (int i = 0; i < N; i++) rand_ops(i);
      #1;
      n_checks++;
      if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b, required 0", req_ready); end
      n_checks++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_busy: rsp_valid %b busy %b, required 0 0", rsp_valid, busy); end
      n_checks++;
      if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h, required 0", rsp_data); end
      tick();
    end
    req_valid = '0; rsp_ready = '1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) set_op(0, k, W'(k + 1));
    req_valid = 4'b0001;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL first_grant: got %b, required 0001", req_ready); end
    tick();
    req_valid = '0;
    for (int d = 1; d <= 3; d++) begin
      #1;
      n_checks++;
      if (rsp_valid[0] !== (d == 3)) begin n_fail++; $display("FAIL first_latency: cycle t+%0d rsp_valid[0] %b, required %b", d, rsp_valid[0], (d == 3)); end
      if (d == 3) begin
        n_checks++;
        if (rsp_data[0 +: W] !== W'(21)) begin n_fail++; $display("FAIL first_sum: got %0d, required 21", rsp_data[0 +: W]); end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] tv [2][6];
    logic [W-1:0] tr [2];
    int           tid [2];
    tv[0] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}; tr[0] = 16'hFFFA; tid[0] = 1;
    tv[1] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0001}; tr[1] = 16'h0001; tid[1] = 2;
    rsp_ready = '1;
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 6; k++) set_op(tid[t], k, tv[t][k]);
      req_valid = '0; req_valid[tid[t]] = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== req_valid) begin n_fail++; $display("FAIL wrap_grant: got %b, required %b", req_ready, req_valid); end
      tick();
      req_valid = '0;
      tick(); tick();
      #1;
      n_checks++;
      if (rsp_valid[tid[t]] !== 1'b1 || rsp_data[tid[t]*W +: W] !== tr[t]) begin
        n_fail++;
        $display("FAIL wrap_sum: slot %0d valid %b data %h, required 1 %h", tid[t], rsp_valid[tid[t]], rsp_data[tid[t]*W +: W], tr[t]);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] er;
    apply_reset();
    req_valid = '1; rsp_ready = '1;
    for (int i = 0; i < N; i++) rand_ops(i);
    for (int c = 0; c < 12; c++) begin
      er = '0; er[c % N] = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== er) begin n_fail++; $display("FAIL rr_grant: cycle %0d got %b, required %b", c, req_ready, er); end
      n_checks++;
      if (busy !== (c > 0)) begin n_fail++; $display("FAIL rr_busy: cycle %0d got %b, required %b", c, busy, (c > 0)); end
      tick();
      rand_ops(c % N);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [N-1:0] er;
    logic [W-1:0] hold;
    logic         seen;
    int           others;
    apply_reset();
    req_valid = '1; rsp_ready = 4'b1011;
    for (int i = 0; i < N; i++) rand_ops(i);
    seen = 1'b0; hold = '0; others = 0;
    for (int c = 0; c < 24; c++) begin
      er = exp_ready();
      #1;
      n_checks++;
      if (req_ready !== er) begin n_fail++; $display("FAIL bp_grant: cycle %0d got %b, required %b", c, req_ready, er); end
      if (m_st[2] == ST_DONE) begin
        if (!seen) begin seen = 1'b1; hold = m_data[2]; end
        n_checks++;
        if (req_ready[2] !== 1'b0 || rsp_data[2*W +: W] !== hold) begin
          n_fail++;
          $display("FAIL bp_hold: req_ready[2] %b data %h, required 0 %h", req_ready[2], rsp_data[2*W +: W], hold);
        end
      end
      if ((req_ready & 4'b1011) != '0) others++;
      tick();
      for (int i = 0; i < N; i++) if (er[i]) rand_ops(i);
    end
    n_checks++;
    if (others < 12) begin n_fail++; $display("FAIL bp_others: %0d grants to others, required at least 12", others); end
    rsp_ready = '1;
    #1;
    n_checks++;
    if (rsp_valid[2] !== 1'b1 || req_ready[2] !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: rsp_valid[2] %b req_ready[2] %b, required 1 0", rsp_valid[2], req_ready[2]);
    end
    tick();
    er = exp_ready();
    #1;
    n_checks++;
    if (rsp_valid[2] !== 1'b0 || req_ready !== er) begin
      n_fail++; $display("FAIL bp_after: rsp_valid[2] %b req_ready %b, required 0 %b", rsp_valid[2], req_ready, er);
    end
    drain();
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] s0, s1, s3;
    apply_reset();
    rsp_ready = 4'b0001;
    rand_ops(3); s3 = job_sum(3); req_valid = 4'b1000;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL sim_grant3: got %b, required 1000", req_ready); end
    tick();
    rand_ops(1); s1 = job_sum(1); req_valid = 4'b0010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL sim_grant1: got %b, required 0010", req_ready); end
    tick();
    req_valid = '0;
    tick();
    rand_ops(0); s0 = job_sum(0); req_valid = 4'b0001; rsp_ready = 4'b1001;
    #1;
    n_checks++;
    if (rsp_valid !== 4'b1000 || req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL sim_event: rsp_valid %b req_ready %b, required 1000 0001", rsp_valid, req_ready);
    end
    tick();
    req_valid = '0; rsp_ready = 4'b0001;
    #1;
    n_checks++;
    if (rsp_valid !== 4'b0010 || rsp_data[1*W +: W] !== s1 || rsp_data[3*W +: W] !== s3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_after: rsp_valid %b d1 %h d3 %h busy %b, required 0010 %h %h 1", rsp_valid, rsp_data[1*W +: W], rsp_data[3*W +: W], busy, s1, s3);
    end
    tick(); tick();
    #1;
    n_checks++;
    if (rsp_valid !== 4'b0011 || rsp_data[0 +: W] !== s0) begin
      n_fail++; $display("FAIL sim_slot0: rsp_valid %b d0 %h, required 0011 %h", rsp_valid, rsp_data[0 +: W], s0);
    end
    tick();
    #1;
    n_checks++;
    if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL sim_hs0: rsp_valid %b, required 0010", rsp_valid); end
    drain();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rsp_ready = '1; req_valid = 4'b0011;
    rand_ops(0); rand_ops(1);
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_grant0: got %b, required 0001", req_ready); end
    tick();
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_grant1: got %b, required 0010", req_ready); end
    tick();
    req_valid = '0; rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL mid_stale: cycle %0d rsp_valid %b busy %b, required 0 0", c, rsp_valid, busy);
      end
      tick();
    end
    req_valid = '1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr: got %b, required 0001", req_ready); end
    tick();
    drain();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      req_valid = N'($urandom());
      for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) rand_ops(i);
      #1;
      n_checks++;
      if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready: cycle %0d got %b, required %b", c, req_ready, exp_ready()); end
      n_checks++;
      if (rsp_valid !== exp_rsp_valid() || busy !== exp_busy()) begin
        n_fail++; $display("FAIL rnd_valid: cycle %0d rsp_valid %b busy %b, required %b %b", c, rsp_valid, busy, exp_rsp_valid(), exp_busy());
      end
      n_checks++;
      if (rsp_data !== exp_data()) begin n_fail++; $display("FAIL rnd_data: cycle %0d got %h, required %h", c, rsp_data, exp_data()); end
      tick();
    end
    drain();
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    test_reset();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_random();
    tick(); tick();
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL sb_leftover: %0d responses missing, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_arb6.md
# adder_arb6

Round-robin arbiter and scheduler that shares one pipelined 6-operand adder tree among N requesters. Each requester submits a job of six W-bit operands and receives the wrapped sum in a private result slot. The block owns the adder pipeline, tags every job with its requester ID, and steers each result back to the right requester. It sits between the requester blocks and the summation datapath and replaces per-requester adder trees.

## Interface
Parameters:
- W, 16, operand and result width
- N, 4, number of requesters (2..8)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  N  bit i: requester i presents a job
- req_ops  in  N*6*W  requester i operands at [(6i+k)*W +: W], k=0..5 (A..F)
- req_ready  out  N  bit i: job i accepted this cycle (one-hot or zero)
- rsp_valid  out  N  bit i: slot i holds a result
- rsp_data  out  N*W  slot i result at [i*W +: W]
- rsp_ready  in  N  bit i: requester i consumes its result
- busy  out  1  any job in flight or any result held

## Operation
- Per-requester slot state: IDLE -> INFLIGHT (on accept) -> DONE (result written) -> IDLE (on rsp_valid[i] & rsp_ready[i]). Each requester has at most one outstanding job.
- Eligible(i) = req_valid[i] & slot i IDLE. A slot freed by a response handshake in cycle t is not eligible until cycle t+1.
- Arbitration is combinational and round-robin. Search starts at ptr and wraps modulo N. The first eligible requester is granted: req_ready[grant] = 1. At most one grant per cycle.
- On a grant, ptr <= grant+1 (mod N). With no grant, ptr holds.
- req_ready depends only on req_valid and registered state. It never depends on rsp_ready.
- Pipeline, with a valid bit and ID carried alongside:
  - S1: p0=A+B, p1=C+D, p2=E+F.
  - S2: s01=p0+p1; p2 delayed one stage.
  - S3: writes s01+p2d into rsp_data[id], and sets rsp_valid[id].
- Arithmetic: all sums are W bits, modulo 2^W. Carries are discarded.
- The pipeline never stalls. Issue is throttled only by slot state, so S3 never finds its target slot in DONE.
- rsp_data[i] holds its value until overwritten by the next result for i. It is not cleared on handshake.
- busy = any slot not IDLE.

## Timing
- Reset values:
  - req_ready: 0
  - rsp_valid: 0
  - rsp_data: all 0
  - busy: 0
  - ptr: 0
  - all slots IDLE, all pipeline valids 0
- Reset mid-operation discards in-flight jobs and held results. No response is produced after rst_n deasserts for a job accepted before reset.
- Latency: a job accepted in cycle t (req_ready[i]=1) produces rsp_valid[i]=1 in cycle t+3.
- Throughput: 1 job/cycle aggregate, from distinct requesters.
- A single requester completing each response with rsp_ready held high is re-granted every 4 cycles: accept t, rsp t+3, handshake t+3, accept t+4.
- Simultaneous events in one cycle are all honoured:
  - an S3 writeback to slot j,
  - a handshake on slot k,
  - a grant to requester m.
- rsp_valid[i] stays high until rsp_ready[i] is sampled high.

## Test plan
- Reset check: hold rst_n=0 with random inputs -> req_ready=0, rsp_valid=0, busy=0. Release rst_n; requester 0 submits A..F=1,2,3,4,5,6 in cycle t -> rsp_valid[0] rises in cycle t+3 with rsp_data[0]=21.
- Wrap-around: W=16, all six operands 0xFFFF -> result 0xFFFA. Operands 0x8000,0x8000,0,0,0,1 -> 0x0001.
- Round-robin fairness: all four requesters valid continuously, rsp_ready=1 -> grants in cycles 0,1,2,3 go to 0,1,2,3. Grant 0 repeats at cycle 4. Each result equals its own operand sum.
- Backpressure: requester 2 holds rsp_ready[2]=0 -> req_valid[2] is never granted and rsp_data[2] stays stable. Other requesters keep being granted. Raise rsp_ready[2] -> handshake, then a grant to 2 no earlier than the next cycle.
- Simultaneous events: in one cycle, S3 writes slot 1, slot 3 handshakes, and requester 0 is granted -> all three take effect, and there is no lost or duplicated response.
- Reset mid-operation: assert rst_n=0 one cycle after accepting jobs from requesters 0 and 1 -> after release, no rsp_valid appears for those jobs, and the next grant goes to requester 0 (ptr=0).
